// File: rtl/sample_recorder_ring.sv
// rtl/sample_recorder_ring.sv - ring-buffer logic-analyser capture engine with pre-trigger window
module sample_recorder_ring #(
    parameter int CHANNELS   = 16,
    parameter int ADDR_WIDTH = 13,
    parameter int DIV_WIDTH  = 24
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  run,
    input  logic                  abort,
    input  logic [DIV_WIDTH-1:0]  clock_divider,
    input  logic [ADDR_WIDTH:0]   sample_count,
    input  logic [ADDR_WIDTH:0]   pretrigger_count,
    input  logic [CHANNELS-1:0]   trigger_mask,
    input  logic [CHANNELS-1:0]   trigger_value,
    input  logic [CHANNELS-1:0]   trigger_edge,
    input  logic                  trigger_immediate,
    input  logic [CHANNELS-1:0]   channels,
    output logic                  write_en,
    output logic [ADDR_WIDTH-1:0] write_address,
    output logic [CHANNELS-1:0]   write_data,
    output logic [ADDR_WIDTH-1:0] trigger_address,
    output logic                  wrapped,
    output logic                  busy,
    output logic                  finished
);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAIT, S_POST, S_DONE} state_t;

    localparam logic [ADDR_WIDTH:0]   DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0]  DIV_ONE  = DIV_WIDTH'(1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [DIV_WIDTH-1:0]  div_cnt;
    logic [ADDR_WIDTH:0]   count_left;
    logic [CHANNELS-1:0]   prev_sample;
    logic                  prev_valid;

    logic [DIV_WIDTH-1:0]  cfg_div;
    logic [ADDR_WIDTH:0]   cfg_n;
    logic [ADDR_WIDTH:0]   cfg_p;
    logic [CHANNELS-1:0]   cfg_mask;
    logic [CHANNELS-1:0]   cfg_value;
    logic [CHANNELS-1:0]   cfg_edge;
    logic                  cfg_imm;

    logic [ADDR_WIDTH:0]   eff_n;
    logic [ADDR_WIDTH:0]   eff_p;
    logic [ADDR_WIDTH:0]   post_len;
    logic [CHANNELS-1:0]   edge_bits;
    logic                  level_ok;
    logic                  edge_ok;
    logic                  hit;
    logic                  strobe;
    logic                  capturing;

    always_comb begin
        eff_n = (sample_count == '0 || sample_count > DEPTH) ? DEPTH : sample_count;
        eff_p = (pretrigger_count > eff_n - CNT_ONE) ? eff_n - CNT_ONE : pretrigger_count;
        post_len  = cfg_n - cfg_p - CNT_ONE;
        edge_bits = cfg_mask & cfg_edge;
        level_ok  = ((channels ^ cfg_value) & cfg_mask) == '0;
        // Edge qualification needs a previous sample, so it can never hold on the first one.
        edge_ok   = (edge_bits == '0) ||
                    (prev_valid && (((channels ^ prev_sample) & edge_bits) == edge_bits));
        hit       = cfg_imm || (level_ok && edge_ok);
        strobe    = (div_cnt == '0);
        capturing = (state == S_ARM) || (state == S_WAIT) || (state == S_POST);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            ptr             <= '0;
            div_cnt         <= '0;
            count_left      <= '0;
            prev_sample     <= '0;
            prev_valid      <= 1'b0;
            cfg_div         <= '0;
            cfg_n           <= '0;
            cfg_p           <= '0;
            cfg_mask        <= '0;
            cfg_value       <= '0;
            cfg_edge        <= '0;
            cfg_imm         <= 1'b0;
            write_en        <= 1'b0;
            write_address   <= '0;
            write_data      <= '0;
            trigger_address <= '0;
            wrapped         <= 1'b0;
            busy            <= 1'b0;
            finished        <= 1'b0;
        end else begin
            write_en <= 1'b0;
            if (run) begin
                cfg_div         <= clock_divider;
                cfg_n           <= eff_n;
                cfg_p           <= eff_p;
                cfg_mask        <= trigger_mask;
                cfg_value       <= trigger_value;
                cfg_edge        <= trigger_edge;
                cfg_imm         <= trigger_immediate;
                state           <= (eff_p == '0) ? S_WAIT : S_ARM;
                count_left      <= eff_p;
                ptr             <= '0;
                div_cnt         <= '0;
                prev_valid      <= 1'b0;
                trigger_address <= '0;
                wrapped         <= 1'b0;
                finished        <= 1'b0;
                busy            <= 1'b1;
            end else if (abort && capturing) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else if (capturing) begin
                if (strobe) begin
                    div_cnt       <= cfg_div;
                    write_en      <= 1'b1;
                    write_address <= ptr;
                    write_data    <= channels;
                    ptr           <= ptr + PTR_ONE;
                    prev_sample   <= channels;
                    prev_valid    <= 1'b1;
                    if (state != S_POST && ptr == '1)
                        wrapped <= 1'b1;
                    case (state)
                        S_ARM: begin
                            if (count_left == CNT_ONE)
                                state <= S_WAIT;
                            count_left <= count_left - CNT_ONE;
                        end
                        S_WAIT: begin
                            if (hit) begin
                                trigger_address <= ptr;
                                count_left      <= post_len;
                                state           <= (post_len == '0) ? S_DONE : S_POST;
                            end
                        end
                        default: begin
                            if (count_left == CNT_ONE)
                                state <= S_DONE;
                            count_left <= count_left - CNT_ONE;
                        end
                    endcase
                end else begin
                    div_cnt <= div_cnt - DIV_ONE;
                end
            end else if (state == S_DONE) begin
                // Completion becomes visible the cycle after the last write strobe.
                busy     <= 1'b0;
                finished <= 1'b1;
            end
        end
    end

endmodule
